// File: rtl/iobs_pkg.sv
// iobs_pkg: shared FSM state encoding and default synchronizer depth for the I/O bus slave
package iobs_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACT  = 2'd2,
    DONE = 2'd3
  } state_t;
  localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/iobs_sync.sv
// iobs_sync: N-stage single-bit synchronizer (clk, rst, i_d async in, o_q synchronized out)
module iobs_sync #(
  parameter int N = iobs_pkg::SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [N-1:0] r_q;
  always_ff @(posedge clk) r_q <= rst ? '0 : {r_q[N-2:0], i_d};
  assign o_q = r_q[N-1];
endmodule

// File: rtl/iobs.sv
// iobs: I/O bus slave stage; CPU cycles (CPUREQ/WE/LDS/UDS -> ACK/BERR/ALE1) to PDS master (IOREQ/IOLDS/IOUDS/IOWE <- IOACT/IOBERR), PWERR sticky
module iobs
  import iobs_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter bit POST_WRITES = 1'b1
) (
  input  logic FCLK,
  input  logic RES,
  input  logic CPUREQ,
  input  logic CPUWE,
  input  logic CPULDS,
  input  logic CPUUDS,
  output logic ACK,
  output logic BERR,
  output logic ALE1,
  output logic IOREQ,
  output logic IOLDS,
  output logic IOUDS,
  output logic IOWE,
  input  logic IOACT,
  input  logic IOBERR,
  output logic PWERR
);
  logic w_act;
  logic w_berr;
  logic w_posted;
  logic w_accept;
  state_t r_state;
  logic [SYNC_STAGES-1:0] r_warm;
  iobs_sync #(.N(SYNC_STAGES)) u_sync_act (.clk(FCLK), .rst(RES), .i_d(IOACT), .o_q(w_act));
  iobs_sync #(.N(SYNC_STAGES)) u_sync_berr (.clk(FCLK), .rst(RES), .i_d(IOBERR), .o_q(w_berr));
  assign w_posted = POST_WRITES && IOWE;
  // r_warm holds off acceptance until the synchronizer has refilled after reset, so an orphaned master cycle is seen
  assign w_accept = r_state == IDLE && CPUREQ && !(ACK || BERR) && !w_act && r_warm[SYNC_STAGES-1];
  always_ff @(posedge FCLK) begin
    if (RES) begin
      r_state <= IDLE;
      r_warm <= '0;
      ACK <= 1'b0;
      BERR <= 1'b0;
      ALE1 <= 1'b0;
      IOREQ <= 1'b0;
      IOLDS <= 1'b0;
      IOUDS <= 1'b0;
      IOWE <= 1'b0;
      PWERR <= 1'b0;
    end else begin
      r_warm <= {r_warm[SYNC_STAGES-2:0], 1'b1};
      ALE1 <= w_accept;
      if (!CPUREQ) begin
        ACK <= 1'b0;
        BERR <= 1'b0;
      end
      case (r_state)
        IDLE: if (w_accept) begin
          IOWE <= CPUWE;
          IOLDS <= CPULDS;
          IOUDS <= CPUUDS;
          IOREQ <= 1'b1;
          r_state <= REQ;
          if (POST_WRITES && CPUWE) ACK <= 1'b1;
        end
        REQ: if (w_act) begin
          IOREQ <= 1'b0;
          r_state <= ACT;
        end
        ACT: if (!w_act) begin
          r_state <= DONE;
          if (w_posted) begin
            if (w_berr) PWERR <= 1'b1;
          end else begin
            ACK <= !w_berr;
            BERR <= w_berr;
          end
        end
        DONE: begin
          IOWE <= 1'b0;
          IOLDS <= 1'b0;
          IOUDS <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_iobs.sv
// tb_iobs: directed scoreboard bench for iobs with a behavioural PDS master
module tb_iobs;
  localparam int SYNC = 2;
  logic FCLK = 1'b0, RES = 1'b1, CPUREQ = 1'b0, CPUWE = 1'b0, CPULDS = 1'b0, CPUUDS = 1'b0;
  logic IOACT = 1'b0, IOBERR = 1'b0;
  logic ACK, BERR, ALE1, IOREQ, IOLDS, IOUDS, IOWE, PWERR;
  int n_chk = 0, n_err = 0, cyc = 0, t_rise = 0, t_fall = 0, n_ale = 0, n_ioreq = 0;
  logic m_err = 1'b0, p_ale = 1'b0, p_ioreq = 1'b0;
  logic [2:0] q_io[$];
  logic [1:0] q_cpl[$];
  iobs #(.SYNC_STAGES(SYNC), .POST_WRITES(1'b1)) dut (
    .FCLK(FCLK), .RES(RES), .CPUREQ(CPUREQ), .CPUWE(CPUWE), .CPULDS(CPULDS), .CPUUDS(CPUUDS),
    .ACK(ACK), .BERR(BERR), .ALE1(ALE1), .IOREQ(IOREQ), .IOLDS(IOLDS), .IOUDS(IOUDS), .IOWE(IOWE),
    .IOACT(IOACT), .IOBERR(IOBERR), .PWERR(PWERR)
  );
  always #5 FCLK = ~FCLK;
  always @(posedge FCLK) cyc++;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // master: IOACT rises 3 cycles after IOREQ is seen, stays high 10 cycles, IOBERR valid at the fall
  initial forever begin
    @(posedge FCLK);
    #1;
    if (IOREQ === 1'b1) begin
      repeat (3) @(posedge FCLK);
      #1;
      IOBERR = 1'b0;
      IOACT = 1'b1;
      t_rise = cyc;
      repeat (10) @(posedge FCLK);
      #1;
      IOBERR = m_err;
      IOACT = 1'b0;
      t_fall = cyc;
    end
  end
  always @(negedge FCLK) begin
    if (ALE1 === 1'b1) begin
      n_ale++;
      chk("ale1_width", 8'(p_ale), 8'd0);
      if (q_io.size() == 0) chk("ale1_unexpected", 8'(ALE1), 8'd0);
      else chk("io_capture", 8'({IOWE, IOLDS, IOUDS}), 8'(q_io.pop_front()));
    end
    if (IOREQ === 1'b1 && !p_ioreq) n_ioreq++;
    if (IOREQ === 1'b0 && p_ioreq && !RES) chk("ioreq_fall_lat", 8'(cyc - t_rise), 8'(SYNC + 1));
    p_ale = ALE1;
    p_ioreq = IOREQ;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge FCLK);
  endtask
  task automatic cpu_req(input logic we, input logic lds, input logic uds, input logic [1:0] cpl);
    q_io.push_back({we, lds, uds});
    q_cpl.push_back(cpl);
    CPUWE = we;
    CPULDS = lds;
    CPUUDS = uds;
    CPUREQ = 1'b1;
  endtask
  task automatic wait_cpl(input string tag, input bit lat);
    int k = 0;
    while (!(ACK || BERR) && k < 200) begin
      tick(1);
      k++;
    end
    if (k >= 200) begin
      n_chk++;
      n_err++;
      $error("FAIL %s_timeout: no ACK/BERR after %0d cycles", tag, k);
      if (q_cpl.size() > 0) q_cpl.delete(0);
    end else begin
      chk(tag, 8'({ACK, BERR}), 8'(q_cpl.pop_front()));
      if (lat) chk({tag, "_lat"}, 8'(cyc - t_fall), 8'(SYNC + 1));
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int a0, r0, k;
    logic bad;
    tick(3);
    chk("reset_outs", {ACK, BERR, ALE1, IOREQ, IOLDS, IOUDS, IOWE, PWERR}, 8'd0);
    RES = 1'b0;
    tick(4);
    cpu_req(1'b0, 1'b1, 1'b1, 2'b10);
    wait_cpl("read_ok", 1'b1);
    tick(3);
    chk("read_ack_hold", 8'({ACK, BERR}), 8'b10);
    CPUREQ = 1'b0;
    tick(1);
    chk("read_ack_drop", 8'({ACK, BERR}), 8'd0);
    m_err = 1'b1;
    cpu_req(1'b0, 1'b1, 1'b1, 2'b01);
    wait_cpl("read_berr", 1'b1);
    chk("read_berr_pwerr", 8'(PWERR), 8'd0);
    CPUREQ = 1'b0;
    tick(1);
    chk("read_berr_drop", 8'({ACK, BERR}), 8'd0);
    m_err = 1'b0;
    a0 = n_ale;
    cpu_req(1'b1, 1'b1, 1'b0, 2'b10);
    wait_cpl("pw_ack", 1'b0);
    chk("pw_ack_before_ioact", 8'(IOACT), 8'd0);
    chk("pw_ack_with_ale1", 8'(ALE1), 8'd1);
    CPUREQ = 1'b0;
    tick(1);
    chk("pw_ack_drop", 8'(ACK), 8'd0);
    tick(2);
    cpu_req(1'b0, 1'b1, 1'b1, 2'b10);
    tick(5);
    chk("rd_not_captured_ale", 8'(n_ale - a0), 8'd1);
    chk("rd_not_captured_we", 8'(IOWE), 8'd1);
    wait_cpl("rd_after_pw", 1'b1);
    chk("rd_after_pw_ales", 8'(n_ale - a0), 8'd2);
    CPUREQ = 1'b0;
    tick(1);
    m_err = 1'b1;
    cpu_req(1'b1, 1'b1, 1'b1, 2'b10);
    wait_cpl("pwerr_ack", 1'b0);
    CPUREQ = 1'b0;
    bad = 1'b0;
    repeat (30) begin
      tick(1);
      bad |= BERR;
    end
    chk("pwerr_no_berr", 8'(bad), 8'd0);
    chk("pwerr_set", 8'(PWERR), 8'd1);
    tick(100);
    chk("pwerr_sticky", 8'(PWERR), 8'd1);
    m_err = 1'b0;
    RES = 1'b1;
    tick(2);
    RES = 1'b0;
    chk("pwerr_res", 8'(PWERR), 8'd0);
    tick(4);
    cpu_req(1'b0, 1'b1, 1'b1, 2'b10);
    q_io.push_back(3'b011);
    k = 0;
    while (!IOACT && k < 100) begin
      tick(1);
      k++;
    end
    chk("rst_mid_ioact_seen", 8'(IOACT), 8'd1);
    tick(4);
    RES = 1'b1;
    tick(1);
    RES = 1'b0;
    chk("rst_mid_outs", {ACK, BERR, ALE1, IOREQ, IOLDS, IOUDS, IOWE, PWERR}, 8'd0);
    bad = 1'b0;
    k = 0;
    while (IOACT && k < 100) begin
      tick(1);
      bad |= ALE1 | IOREQ;
      k++;
    end
    chk("rst_mid_no_req", 8'(bad), 8'd0);
    wait_cpl("rst_mid_read", 1'b1);
    a0 = n_ale;
    r0 = n_ioreq;
    tick(50);
    chk("held_ale", 8'(n_ale - a0), 8'd0);
    chk("held_ioreq", 8'(n_ioreq - r0), 8'd0);
    chk("held_ack", 8'(ACK), 8'd1);
    CPUREQ = 1'b0;
    tick(1);
    chk("held_ack_drop", 8'(ACK), 8'd0);
    tick(2);
    chk("sb_io_empty", 8'(q_io.size()), 8'd0);
    chk("sb_cpl_empty", 8'(q_cpl.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
